// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 16-bit down-counter with prescaler, auto-reload and level irq.
// Optional MMIO_TIMER_SNAPSHOT_EN: a CNT_LO read latches count[15:8] so CNT_HI reads are tear-free.
module mmio_timer #(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RW,
  input  logic [15:0] AD,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        hit,
  output logic        irq
);
  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [15:0]   count;
  logic [15:0]   reload;
  logic [2:0]    ctrl;
  logic          flag;
  logic [PW-1:0] psc;
  logic          sel;
  logic          wr_en;
  logic          rd_en;
  logic          tick;
  logic          expire;
  logic [7:0]    cnt_hi_rd;
  logic [7:0]    rd_data;

  assign sel    = (AD[15:2] == BASE[15:2]);
  assign wr_en  = sel & ~RW;
  assign rd_en  = sel & RW;
  assign tick   = ctrl[0] && (psc == PS_LAST);
  assign expire = tick && (count == 16'd0);

`ifdef MMIO_TIMER_SNAPSHOT_EN
  logic [7:0] snap_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      snap_hi <= '0;
    else if (rd_en && AD[1:0] == 2'd0)
      snap_hi <= count[15:8];
  end

  assign cnt_hi_rd = snap_hi;
`else
  assign cnt_hi_rd = count[15:8];
`endif

  always_comb begin
    rd_data = 8'h00;
    case (AD[1:0])
      2'd0:    rd_data = count[7:0];
      2'd1:    rd_data = cnt_hi_rd;
      2'd2:    rd_data = {5'b0, ctrl};
      default: rd_data = {7'b0, flag};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      ctrl   <= '0;
      flag   <= 1'b0;
      psc    <= '0;
      D_out  <= '0;
      hit    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (!ctrl[0] || tick)
        psc <= '0;
      else
        psc <= psc + 1'b1;

      if (tick) begin
        if (count != 16'd0)
          count <= count - 1'b1;
        else if (ctrl[1])
          count <= reload;
        else
          ctrl[0] <= 1'b0;
      end

      // Expiry is assigned after the STATUS clear so a same-edge set wins.
      if (wr_en && AD[1:0] == 2'd3 && D_in[0])
        flag <= 1'b0;
      if (expire)
        flag <= 1'b1;

      // Bus writes come last so they override tick-driven count/psc/EN updates.
      if (wr_en) begin
        case (AD[1:0])
          2'd0: reload[7:0] <= D_in;
          2'd1: begin
            reload[15:8] <= D_in;
            count        <= {D_in, reload[7:0]};
            psc          <= '0;
          end
          2'd2:    ctrl <= D_in[2:0];
          default: ;
        endcase
      end

      irq <= flag & ctrl[2];
      hit <= rd_en;
      if (rd_en)
        D_out <= rd_data;
    end
  end
endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: one PRESCALE=1 and one PRESCALE=4 instance on a shared bus.
module tb_mmio_timer;
  localparam logic [15:0] BASE = 16'hD000;

  logic        clk;
  logic        rst;
  logic        rw;
  logic [15:0] ad;
  logic [7:0]  d_in;
  logic [7:0]  d_out1, d_out4;
  logic        hit1, hit4;
  logic        irq1, irq4;
  logic [7:0]  exp_hi;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mmio_timer #(.BASE(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .RW(rw), .AD(ad), .D_in(d_in),
    .D_out(d_out1), .hit(hit1), .irq(irq1)
  );

  mmio_timer #(.BASE(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .RW(rw), .AD(ad), .D_in(d_in),
    .D_out(d_out4), .hit(hit4), .irq(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    rw = 1'b0; ad = a; d_in = d;
    @(negedge clk);
    rw = 1'b1; ad = 16'h0000; d_in = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a);
    rw = 1'b1; ad = a;
    @(negedge clk);
    ad = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rw = 1'b1; ad = 16'h0000; d_in = 8'h00;
    @(negedge clk);

    // Reset then idle
    do_reset();
    idle(20);
    chk("rst_dout", 16'(d_out1), 16'h00);
    chk("rst_hit", 16'(hit1), 16'h0);
    chk("rst_irq1", 16'(irq1), 16'h0);
    chk("rst_irq4", 16'(irq4), 16'h0);
    rd(BASE + 16'd3);
    chk("rst_status", 16'(d_out1), 16'h00);
    chk("rst_status_hit", 16'(hit1), 16'h1);

    // One-shot on PRESCALE=1: load 3, EN|IE; flag at CTRL edge +4, irq at +5
    do_reset();
    wr(BASE + 16'd0, 8'h03);
    wr(BASE + 16'd1, 8'h00);
    wr(BASE + 16'd2, 8'h05);
    idle(4);
    chk("os_irq_early", 16'(irq1), 16'h0);
    idle(1);
    chk("os_irq", 16'(irq1), 16'h1);
    rd(BASE + 16'd2);
    chk("os_ctrl", 16'(d_out1), 16'h04);
    rd(BASE + 16'd0);
    chk("os_cnt_lo", 16'(d_out1), 16'h00);
    rd(BASE + 16'd1);
    chk("os_cnt_hi", 16'(d_out1), 16'h00);
    rd(BASE + 16'd3);
    chk("os_status", 16'(d_out1), 16'h01);

    // Auto-reload on PRESCALE=4: reload 2, expiries every 12 cycles
    do_reset();
    wr(BASE + 16'd0, 8'h02);
    wr(BASE + 16'd1, 8'h00);
    wr(BASE + 16'd2, 8'h07);
    idle(12);
    chk("ar_p1_early", 16'(irq4), 16'h0);
    idle(1);
    chk("ar_p1", 16'(irq4), 16'h1);
    wr(BASE + 16'd3, 8'h01);
    idle(10);
    chk("ar_p2_early", 16'(irq4), 16'h0);
    idle(1);
    chk("ar_p2", 16'(irq4), 16'h1);
    wr(BASE + 16'd3, 8'h01);
    idle(9);
    chk("ar_cleared", 16'(irq4), 16'h0);
    wr(BASE + 16'd3, 8'h01);
    chk("ar_p3_early", 16'(irq4), 16'h0);
    idle(1);
    chk("ar_set_wins", 16'(irq4), 16'h1);
    rd(BASE + 16'd3);
    chk("ar_status", 16'(d_out4), 16'h01);

    // Snapshot vs live high byte on PRESCALE=4
    do_reset();
    wr(BASE + 16'd0, 8'h00);
    wr(BASE + 16'd1, 8'h01);
    wr(BASE + 16'd2, 8'h01);
    rd(BASE + 16'd0);
    chk("snap_lo", 16'(d_out4), 16'h00);
    idle(5);
    rd(BASE + 16'd1);
`ifdef MMIO_TIMER_SNAPSHOT_EN
    exp_hi = 8'h01;
`else
    exp_hi = 8'h00;
`endif
    chk("snap_hi", 16'(d_out4), 16'(exp_hi));

    // Decode and latency
    rd(BASE + 16'd4);
    chk("dec_above_hit", 16'(hit4), 16'h0);
    chk("dec_above_hold", 16'(d_out4), 16'(exp_hi));
    rd(BASE - 16'd1);
    chk("dec_below_hit", 16'(hit4), 16'h0);
    rd(BASE + 16'd2);
    chk("dec_ctrl_hit", 16'(hit4), 16'h1);
    chk("dec_ctrl_data", 16'(d_out4), 16'h01);
    idle(1);
    chk("dec_hit_drop", 16'(hit4), 16'h0);

    // Async reset mid-count on PRESCALE=1
    do_reset();
    wr(BASE + 16'd0, 8'h10);
    wr(BASE + 16'd1, 8'h00);
    wr(BASE + 16'd2, 8'h07);
    rd(BASE + 16'd0);
    chk("ar_mid_cnt", 16'(d_out1), 16'h10);
    chk("ar_mid_hit", 16'(hit1), 16'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_dout", 16'(d_out1), 16'h00);
    chk("async_hit", 16'(hit1), 16'h0);
    chk("async_irq", 16'(irq1), 16'h0);
    #1 rst = 1'b0;
    idle(40);
    chk("post_rst_irq", 16'(irq1), 16'h0);
    rd(BASE + 16'd3);
    chk("post_rst_status", 16'(d_out1), 16'h00);
    rd(BASE + 16'd0);
    chk("post_rst_cnt", 16'(d_out1), 16'h00);

    if (n_total != n_pass + n_fail)
      $display("check bookkeeping inconsistent");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
